// File: rtl/dispatch_pkg.sv
// Shared constants for the dispatch stage: FU indices, register file geometry
// and default reservation-station depths.
package dispatch_pkg;

    localparam int NUM_FU        = 4;
    localparam int FU_ALU        = 0;
    localparam int FU_LSU        = 1;
    localparam int FU_MUL        = 2;
    localparam int FU_BR         = 3;

    localparam int NUM_ARCH_REGS = 32;
    localparam int REG_ADDR_W    = 5;

    localparam int ALU_RS_DEPTH_DEF = 4;
    localparam int LSU_RS_DEPTH_DEF = 4;
    localparam int MUL_RS_DEPTH_DEF = 2;
    localparam int BR_RS_DEPTH_DEF  = 2;

endpackage

// File: rtl/dispatch_unit_fu_credit.sv
// Saturating up/down credit counter tracking free entries of one reservation
// station; avail_o is high while at least one entry is free.
module fu_credit #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic take_i,
    input  logic give_i,
    output logic avail_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // take and give in the same cycle cancel; a give at full depth is dropped
    always_comb begin
        cnt_d = cnt_q;
        if (take_i && !give_i) begin
            cnt_d = cnt_q - 1'b1;
        end else if (give_i && !take_i && cnt_q != CNT_W'(DEPTH)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= CNT_W'(DEPTH);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign avail_o = (cnt_q != '0);

    a_no_credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(give_i && !take_i && cnt_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/dispatch_unit.sv
// Registered dispatch stage: routes decoded instructions to one of four RS,
// tracks RS credits and a destination-register busy scoreboard cleared by the CDB.
// Optional macro DISPATCH_CDB_BYPASS_EN lets a same-cycle CDB broadcast count as ready.
module dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int ALU_RS_DEPTH = ALU_RS_DEPTH_DEF,
    parameter int LSU_RS_DEPTH = LSU_RS_DEPTH_DEF,
    parameter int MUL_RS_DEPTH = MUL_RS_DEPTH_DEF,
    parameter int BR_RS_DEPTH  = BR_RS_DEPTH_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        inst_valid_i,
    input  logic [31:0] inst_i,
    input  logic        alu_i,
    input  logic        lsu_i,
    input  logic        mul_i,
    input  logic        br_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    output logic        inst_ready_o,
    input  logic        cdb_en_i,
    input  logic [4:0]  cdb_reg_addr_i,
    input  logic        alu_free_i,
    input  logic        lsu_free_i,
    input  logic        mul_free_i,
    input  logic        br_free_i,
    output logic        alu_valid_o,
    output logic        lsu_valid_o,
    output logic        mul_valid_o,
    output logic        br_valid_o,
    output logic [31:0] inst_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    output logic        illegal_o
);

    logic [NUM_FU-1:0]        cls, avail, take, give;
    logic [NUM_ARCH_REGS-1:0] busy_q, busy_d;
    logic [NUM_FU-1:0]        valid_q, valid_d;
    logic                     illegal_q, illegal_d;
    logic [31:0]              inst_q, inst_d;
    logic [REG_ADDR_W-1:0]    rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    logic                     rs1_busy_q, rs1_busy_d, rs2_busy_q, rs2_busy_d;
    logic                     class_present, credit_ok, writes_rd, stall, fire;
    logic                     rd_busy, rs1_busy_now, rs2_busy_now;

    assign cls  = {br_i, mul_i, lsu_i, alu_i};
    assign give = {br_free_i, mul_free_i, lsu_free_i, alu_free_i};

    fu_credit #(.DEPTH(ALU_RS_DEPTH)) u_alu_credit (.clk_i(clk_i), .reset_i(reset_i),
        .take_i(take[FU_ALU]), .give_i(give[FU_ALU]), .avail_o(avail[FU_ALU]));
    fu_credit #(.DEPTH(LSU_RS_DEPTH)) u_lsu_credit (.clk_i(clk_i), .reset_i(reset_i),
        .take_i(take[FU_LSU]), .give_i(give[FU_LSU]), .avail_o(avail[FU_LSU]));
    fu_credit #(.DEPTH(MUL_RS_DEPTH)) u_mul_credit (.clk_i(clk_i), .reset_i(reset_i),
        .take_i(take[FU_MUL]), .give_i(give[FU_MUL]), .avail_o(avail[FU_MUL]));
    fu_credit #(.DEPTH(BR_RS_DEPTH))  u_br_credit  (.clk_i(clk_i), .reset_i(reset_i),
        .take_i(take[FU_BR]),  .give_i(give[FU_BR]),  .avail_o(avail[FU_BR]));

    // Scoreboard read; busy_q[0] is held at 0 so x0 never reads busy
    always_comb begin
`ifdef DISPATCH_CDB_BYPASS_EN
        rd_busy      = busy_q[rd_addr_i]  && !(cdb_en_i && cdb_reg_addr_i == rd_addr_i);
        rs1_busy_now = busy_q[rs1_addr_i] && !(cdb_en_i && cdb_reg_addr_i == rs1_addr_i);
        rs2_busy_now = busy_q[rs2_addr_i] && !(cdb_en_i && cdb_reg_addr_i == rs2_addr_i);
`else
        rd_busy      = busy_q[rd_addr_i];
        rs1_busy_now = busy_q[rs1_addr_i];
        rs2_busy_now = busy_q[rs2_addr_i];
`endif
    end

    always_comb begin
        class_present = |cls;
        credit_ok     = |(cls & avail);
        writes_rd     = (rd_addr_i != '0) && !br_i && !(lsu_i && inst_i[5]);
        stall         = inst_valid_i && class_present && (!credit_ok || (writes_rd && rd_busy));
        fire          = inst_valid_i && class_present && !stall;
        take          = fire ? cls : '0;
        inst_ready_o  = !stall;

        busy_d = busy_q;
        if (cdb_en_i) begin
            busy_d[cdb_reg_addr_i] = 1'b0;
        end
        if (fire && writes_rd) begin
            busy_d[rd_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;

        valid_d    = take;
        illegal_d  = inst_valid_i && !class_present;
        inst_d     = inst_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        rs1_busy_d = rs1_busy_q;
        rs2_busy_d = rs2_busy_q;
        if (fire) begin
            inst_d     = inst_i;
            rs1_addr_d = rs1_addr_i;
            rs2_addr_d = rs2_addr_i;
            rd_addr_d  = rd_addr_i;
            rs1_busy_d = rs1_busy_now;
            rs2_busy_d = rs2_busy_now;
        end
    end

    // Dispatch register stage
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q     <= '0;
            valid_q    <= '0;
            illegal_q  <= 1'b0;
            inst_q     <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rs1_busy_q <= 1'b0;
            rs2_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
            inst_q     <= inst_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            rs1_busy_q <= rs1_busy_d;
            rs2_busy_q <= rs2_busy_d;
        end
    end

    assign {br_valid_o, mul_valid_o, lsu_valid_o, alu_valid_o} = valid_q;
    assign illegal_o  = illegal_q;
    assign inst_o     = inst_q;
    assign rs1_addr_o = rs1_addr_q;
    assign rs2_addr_o = rs2_addr_q;
    assign rd_addr_o  = rd_addr_q;
    assign rs1_busy_o = rs1_busy_q;
    assign rs2_busy_o = rs2_busy_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Self-checking bench for dispatch_unit: directed scenarios followed by random
// traffic, all checked against a transaction-level model of credits and busy regs.
module tb_dispatch_unit;

    localparam logic [3:0] C_ALU = 4'b0001;
    localparam logic [3:0] C_LSU = 4'b0010;
    localparam logic [3:0] C_MUL = 4'b0100;
    localparam logic [3:0] C_BR  = 4'b1000;
`ifdef DISPATCH_CDB_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i, inst_valid_i, alu_i, lsu_i, mul_i, br_i, inst_ready_o, cdb_en_i;
    logic [31:0] inst_i, inst_o;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i, cdb_reg_addr_i;
    logic        alu_free_i, lsu_free_i, mul_free_i, br_free_i;
    logic        alu_valid_o, lsu_valid_o, mul_valid_o, br_valid_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic        rs1_busy_o, rs2_busy_o, illegal_o;

    always #5 clk = ~clk;

    dispatch_unit dut (
        .clk_i(clk), .reset_i(reset_i), .inst_valid_i(inst_valid_i), .inst_i(inst_i),
        .alu_i(alu_i), .lsu_i(lsu_i), .mul_i(mul_i), .br_i(br_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .inst_ready_o(inst_ready_o), .cdb_en_i(cdb_en_i), .cdb_reg_addr_i(cdb_reg_addr_i),
        .alu_free_i(alu_free_i), .lsu_free_i(lsu_free_i), .mul_free_i(mul_free_i),
        .br_free_i(br_free_i), .alu_valid_o(alu_valid_o), .lsu_valid_o(lsu_valid_o),
        .mul_valid_o(mul_valid_o), .br_valid_o(br_valid_o), .inst_o(inst_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o), .illegal_o(illegal_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: credit counts, busy registers, expected output register contents
    int          depth [4] = '{4, 4, 2, 2};
    int          m_cred[4];
    bit          m_busy[32];
    logic [3:0]  e_valid;
    logic        e_ill, e_b1, e_b2;
    logic [31:0] e_inst;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        last_ready;

    function automatic int fu_of(input logic [3:0] c);
        for (int i = 0; i < 4; i++) if (c[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] a1, input logic [4:0] a2);
        return {7'd0, a2, a1, 3'd0, rd, opc};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_cred[i] = depth[i];
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
        e_valid = '0; e_ill = 0; e_inst = '0; e_rs1 = '0; e_rs2 = '0; e_rd = '0;
        e_b1 = 0; e_b2 = 0;
    endtask

    task automatic step(input logic rst, input logic v, input logic [3:0] c, input logic [31:0] ins,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                        input logic ce, input logic [4:0] ca, input logic [3:0] fr);
        int  f;
        bit  present, wr, rdb, stall, fire;
        reset_i = rst; inst_valid_i = v; {br_i, mul_i, lsu_i, alu_i} = c; inst_i = ins;
        rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = ad; cdb_en_i = ce; cdb_reg_addr_i = ca;
        {br_free_i, mul_free_i, lsu_free_i, alu_free_i} = fr;
        #1;
        f       = fu_of(c);
        present = (c != 0);
        wr      = (ad != 0) && (f != 3) && !(f == 1 && ins[5]);
        rdb     = m_busy[ad] && !(BYPASS && ce && ca == ad);
        stall   = 0;
        if (v && present) stall = (m_cred[f] == 0) || (wr && rdb);
        fire    = v && present && !stall;
        check_eq("ready", inst_ready_o, !stall);
        last_ready = !stall;
        if (rst) begin
            model_reset();
        end else begin
            e_valid = fire ? c : 4'b0;
            e_ill   = v && !present;
            if (fire) begin
                e_inst = ins; e_rs1 = a1; e_rs2 = a2; e_rd = ad;
                e_b1 = m_busy[a1] && !(BYPASS && ce && ca == a1);
                e_b2 = m_busy[a2] && !(BYPASS && ce && ca == a2);
            end
            for (int i = 0; i < 4; i++) begin
                m_cred[i] += int'(fr[i]);
                if (fire && f == i) m_cred[i]--;
                if (m_cred[i] > depth[i]) m_cred[i] = depth[i];
            end
            if (ce) m_busy[ca] = 1'b0;
            if (fire && wr) m_busy[ad] = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq("valid_ill", {br_valid_o, mul_valid_o, lsu_valid_o, alu_valid_o, illegal_o},
                 {e_valid, e_ill});
        check_eq("inst", inst_o, e_inst);
        check_eq("addrs", {rs1_addr_o, rs2_addr_o, rd_addr_o}, {e_rs1, e_rs2, e_rd});
        check_eq("busy_flags", {rs1_busy_o, rs2_busy_o}, {e_b1, e_b2});
    endtask

    task automatic idle(input logic [3:0] fr);
        step(0, 0, 4'b0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, fr);
    endtask

    task automatic cdb(input logic [4:0] r);
        step(0, 0, 4'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1, r, 4'b0);
    endtask

    task automatic issue(input logic [3:0] c, input logic [31:0] ins, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] ad);
        step(0, 1, c, ins, a1, a2, ad, 0, 5'd0, 4'b0);
    endtask

    task automatic drain();
        logic [3:0] fr;
        for (int k = 0; k < 8; k++) begin
            fr = '0;
            for (int i = 0; i < 4; i++) fr[i] = (m_cred[i] < depth[i]);
            if (fr != 0) idle(fr);
        end
    endtask

    initial begin
        logic        h_v, h_rst, h_ce;
        logic [3:0]  h_c, h_fr;
        logic [31:0] h_ins;
        logic [4:0]  h_a1, h_a2, h_ad, h_ca;
        int          r;
        bit          hold;

        model_reset();
        step(1, 0, 4'b0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 4'b0);
        step(1, 0, 4'b0, 32'h0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 4'b0);
        check_eq("reset_outputs", {alu_valid_o, lsu_valid_o, mul_valid_o, br_valid_o, illegal_o,
                 rs1_busy_o, rs2_busy_o}, 0);

        // add x3, x1, x2
        issue(C_ALU, 32'h002081B3, 5'd1, 5'd2, 5'd3);
        check_eq("add_alu_valid", alu_valid_o, 1);
        check_eq("add_rd", rd_addr_o, 3);
        check_eq("add_rs_busy", {rs1_busy_o, rs2_busy_o}, 0);
        idle(4'b0001);

        // ALU credit exhaustion
        for (int i = 0; i < 4; i++) issue(C_ALU, mk(7'h33, 5'(10 + i), 5'd1, 5'd2), 5'd1, 5'd2, 5'(10 + i));
        issue(C_ALU, mk(7'h33, 5'd14, 5'd1, 5'd2), 5'd1, 5'd2, 5'd14);
        check_eq("credit_stall", last_ready, 0);
        step(0, 1, C_ALU, mk(7'h33, 5'd14, 5'd1, 5'd2), 5'd1, 5'd2, 5'd14, 0, 5'd0, 4'b0001);
        check_eq("credit_stall_free_cycle", last_ready, 0);
        issue(C_ALU, mk(7'h33, 5'd14, 5'd1, 5'd2), 5'd1, 5'd2, 5'd14);
        check_eq("credit_resume", alu_valid_o, 1);
        drain();

        // RAW: write x5 then read x5
        issue(C_ALU, mk(7'h33, 5'd5, 5'd1, 5'd2), 5'd1, 5'd2, 5'd5);
        issue(C_ALU, mk(7'h33, 5'd6, 5'd5, 5'd2), 5'd5, 5'd2, 5'd6);
        check_eq("raw_busy", rs1_busy_o, 1);
        cdb(5'd5);
        issue(C_ALU, mk(7'h33, 5'd0, 5'd5, 5'd2), 5'd5, 5'd2, 5'd0);
        check_eq("raw_cleared", rs1_busy_o, 0);
        drain();

        // WAW on x7
        issue(C_MUL, mk(7'h33, 5'd7, 5'd1, 5'd2), 5'd1, 5'd2, 5'd7);
        issue(C_ALU, mk(7'h33, 5'd7, 5'd3, 5'd4), 5'd3, 5'd4, 5'd7);
        check_eq("waw_stall", last_ready, 0);
        step(0, 1, C_ALU, mk(7'h33, 5'd7, 5'd3, 5'd4), 5'd3, 5'd4, 5'd7, 1, 5'd7, 4'b0);
        check_eq("waw_cdb_cycle_ready", last_ready, BYPASS);
        if (!last_ready) issue(C_ALU, mk(7'h33, 5'd7, 5'd3, 5'd4), 5'd3, 5'd4, 5'd7);
        check_eq("waw_dispatched", alu_valid_o, 1);
        cdb(5'd7);
        drain();

        // store and branch never mark rd busy
        issue(C_LSU, mk(7'b0100011, 5'd9, 5'd1, 5'd2), 5'd1, 5'd2, 5'd9);
        check_eq("store_lsu_valid", lsu_valid_o, 1);
        issue(C_BR, mk(7'b1100011, 5'd9, 5'd1, 5'd2), 5'd1, 5'd2, 5'd9);
        check_eq("branch_valid", {br_valid_o, lsu_valid_o}, 2'b10);
        issue(C_ALU, mk(7'h33, 5'd0, 5'd9, 5'd9), 5'd9, 5'd9, 5'd0);
        check_eq("store_br_no_busy", {rs1_busy_o, rs2_busy_o}, 0);
        drain();

        // illegal: valid slot with no class
        issue(4'b0, 32'hDEADBEEF, 5'd1, 5'd2, 5'd3);
        check_eq("illegal_pulse", illegal_o, 1);
        idle(4'b0);
        check_eq("illegal_once", illegal_o, 0);

        // reset during MUL credit stall
        issue(C_MUL, mk(7'h33, 5'd0, 5'd1, 5'd2), 5'd1, 5'd2, 5'd0);
        issue(C_MUL, mk(7'h33, 5'd0, 5'd1, 5'd2), 5'd1, 5'd2, 5'd0);
        issue(C_MUL, mk(7'h33, 5'd0, 5'd1, 5'd2), 5'd1, 5'd2, 5'd0);
        check_eq("mul_stall", last_ready, 0);
        step(1, 1, C_MUL, mk(7'h33, 5'd0, 5'd1, 5'd2), 5'd1, 5'd2, 5'd0, 0, 5'd0, 4'b0);
        check_eq("mul_reset_outputs", {mul_valid_o, inst_o}, 0);
        issue(C_MUL, mk(7'h33, 5'd0, 5'd1, 5'd2), 5'd1, 5'd2, 5'd0);
        check_eq("mul_after_reset", mul_valid_o, 1);
        drain();

        // random traffic
        hold = 0;
        h_v = 0; h_c = '0; h_ins = '0; h_a1 = '0; h_a2 = '0; h_ad = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!hold) begin
                h_v = ($urandom_range(0, 3) != 0);
                r   = $urandom_range(0, 8);
                h_c = (r == 0) ? 4'b0 : 4'(1 << ((r - 1) % 4));
                h_ins = $urandom;
                h_a1 = 5'($urandom_range(0, 7));
                h_a2 = 5'($urandom_range(0, 7));
                h_ad = 5'($urandom_range(0, 7));
            end
            h_rst = ($urandom_range(0, 99) == 0);
            h_ce  = ($urandom_range(0, 2) == 0);
            h_ca  = 5'($urandom_range(0, 7));
            h_fr  = '0;
            for (int i = 0; i < 4; i++)
                h_fr[i] = (m_cred[i] < depth[i]) && ($urandom_range(0, 3) == 0);
            step(h_rst, h_v, h_c, h_ins, h_a1, h_a2, h_ad, h_ce, h_ca, h_fr);
            hold = h_v && !last_ready && !h_rst;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Consumes the per-instruction output of the front-end decoder: FU-class request, source and destination register addresses, and the raw instruction. Routes each instruction to exactly one reservation station (ALU, LSU, MUL, BR) through a registered dispatch stage. Tracks RS occupancy with per-FU credit counters and tracks pending destination registers with a 32-entry busy scoreboard cleared by the CDB. Emits per-operand busy flags so a reservation station knows which source to wait for on the CDB.

## Interface
- ALU_RS_DEPTH, 4: ALU reservation-station entries (credits)
- LSU_RS_DEPTH, 4: LSU reservation-station entries
- MUL_RS_DEPTH, 2: MUL reservation-station entries
- BR_RS_DEPTH, 2: BR reservation-station entries
- clk_i  in  1  clock; everything on rising edge
- reset_i  in  1  synchronous, active-high reset
- inst_valid_i  in  1  decoder slot valid
- inst_i  in  32  raw instruction
- alu_i, lsu_i, mul_i, br_i  in  1 each  FU class from decoder (one-hot or all zero)
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  architectural registers
- inst_ready_o  out  1  dispatch accepts this cycle (combinational)
- cdb_en_i  in  1  CDB broadcast valid
- cdb_reg_addr_i  in  5  register written by CDB broadcast
- alu_free_i, lsu_free_i, mul_free_i, br_free_i  in  1 each  RS entry released (credit return)
- alu_valid_o, lsu_valid_o, mul_valid_o, br_valid_o  out  1 each  registered dispatch strobe, at most one high
- inst_o  out  32  dispatched instruction
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each  dispatched registers
- rs1_busy_o, rs2_busy_o  out  1 each  operand pending on CDB
- illegal_o  out  1  one-cycle pulse: valid slot with no FU class

## Operation
- Target FU = the asserted class input. Credit for FU f is available when its counter is greater than zero.
- writes_rd = rd_addr_i != 0 and the class is not BR and not (LSU with inst_i[5] == 1, i.e. a store).
- stall = inst_valid_i and class present and (target credit == 0 or (writes_rd and busy[rd_addr_i])). The rd-busy term is the WAW stall.
- inst_ready_o = !stall.
- fire = inst_valid_i and class present and !stall. On fire:
  - the target credit is decremented;
  - busy[rd] is set if writes_rd;
  - output registers are loaded.
- Valid slot with no class: it is dropped, illegal_o pulses next cycle, and no state changes.
- busy[0] is always 0.
- The CDB clears busy[cdb_reg_addr_i].
- If a dispatch set and a CDB clear hit the same register in one cycle, the set wins.
- rs1_busy_o = busy[rs1] captured at fire. rs1 == 0 always reads not busy. rs2 works the same way.
- Credit counter update:
  - free only: +1;
  - fire only: -1;
  - both in the same cycle: unchanged;
  - free at full depth: ignored (saturate; simulation assertion fires).
- Upstream holds inst_i and all decoder outputs stable while inst_ready_o is 0.

## Timing
- Reset: all *_valid_o = 0, illegal_o = 0, inst_o = 0, all address outputs = 0, all *_busy_o = 0, busy vector = 0, every credit = its depth.
- Reset asserted mid-stall: it discards the held request and clears the scoreboard.
- Dispatch latency: fire in cycle N makes *_valid_o and the payload valid in cycle N+1 for exactly one cycle. Payload holds its value when not firing.
- Throughput: one dispatch per cycle, back-to-back, while credits last.
- A credit freed in cycle N is usable for a fire in cycle N+1. A CDB clear in cycle N is visible in the scoreboard in cycle N+1, except as noted under Configuration.

## Configuration
- DISPATCH_CDB_BYPASS_EN defined:
  - a CDB broadcast in the same cycle as fire forces the matching rs1_busy_o/rs2_busy_o to 0;
  - a matching CDB broadcast also removes the WAW stall on rd the same cycle.
- Not defined: the scoreboard read is pure register state, so a same-cycle CDB result still reports busy or stalls for one extra cycle.

## Structure
- Shared package dispatch_pkg holds:
  - FU index constants (FU_ALU=0, FU_LSU=1, FU_MUL=2, FU_BR=3) and NUM_FU=4;
  - NUM_ARCH_REGS=32 and REG_ADDR_W=5;
  - the default RS depths.
- One sub-module, fu_credit: a parameterised saturating up/down counter with inputs take/give and output avail. It is instantiated once per FU.

## Test plan
- Reset, then ALU add x3=x1+x2 valid for one cycle -> next cycle alu_valid_o=1, rd_addr_o=3, rs busy flags 0; busy[3]=1; ALU credit 3.
- Five back-to-back ALU instructions writing distinct rd, no frees -> four dispatch; the fifth sees inst_ready_o=0 until alu_free_i pulses, then dispatches the following cycle.
- Write x5 then read x5 -> second dispatch has rs1_busy_o=1. CDB x5 in a later cycle, then read again -> rs1_busy_o=0.
- Write x7 twice -> second stalls (WAW) until cdb_en_i with addr 7. With DISPATCH_CDB_BYPASS_EN it dispatches in the CDB cycle; without it, one cycle later.
- Store (opcode 0100011, rd field 9) and branch -> busy[9] unchanged; lsu_valid_o / br_valid_o each pulse once.
- inst_valid_i=1 with no class -> illegal_o pulses once, credits and busy vector unchanged. Separately, reset_i during a MUL credit stall -> credits return to depth and outputs return to zero.
